// File: rtl/sram_bus_ctrl_pkg.sv
// Shared definitions for the SRAM bus controller: FSM state encoding and debug bus width.
package sram_bus_pkg;

  localparam int DEBUG_W = 8;

  localparam logic [2:0] ENC_IDLE     = 3'd0,
                         ENC_RD       = 3'd1,
                         ENC_WR_SETUP = 3'd2,
                         ENC_WR_PULSE = 3'd3,
                         ENC_WR_HOLD  = 3'd4,
                         ENC_RECOVER  = 3'd5,
                         ENC_SNES     = 3'd6,
                         ENC_TURN     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_RD       = ENC_RD,
    ST_WR_SETUP = ENC_WR_SETUP,
    ST_WR_PULSE = ENC_WR_PULSE,
    ST_WR_HOLD  = ENC_WR_HOLD,
    ST_RECOVER  = ENC_RECOVER,
    ST_SNES     = ENC_SNES,
    ST_TURN     = ENC_TURN
  } state_e;

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// SRAM pin bundle: the controller is master, the memory (or its model) is slave.
interface sram_bus_ctrl_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_in;
  logic [DATA_W-1:0] sram_data_out;
  logic              sram_data_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport master (
    output sram_addr, sram_data_out, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n,
    input  sram_data_in
  );

  modport slave (
    input  sram_addr, sram_data_out, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n,
    output sram_data_in
  );
endinterface

// File: rtl/sram_bus_ctrl_addr_reg.sv
// AVR control-input synchronisers plus the serially loaded, auto-incrementing address register.
module sram_addr_reg #(
  parameter int ADDR_W      = 21,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              avr_sclk,
  input  logic              avr_si,
  input  logic              avr_sreg_en_n,
  input  logic              avr_counter_n,
  input  logic              avr_oe_n,
  input  logic              avr_we_n,
  input  logic              avr_snes_mode,
  input  logic              busy,
  input  logic              recover,
  output logic [ADDR_W-1:0] addr,
  output logic              oe_n_s,
  output logic              we_n_s,
  output logic              snes_s
);

  // bit order: {snes_mode, we_n, oe_n, counter_n, sreg_en_n, si, sclk}; active-low inputs idle high
  localparam logic [6:0] SYNC_RST = 7'b0111100;

  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] ctl_s;
  logic       sclk_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {avr_snes_mode, avr_we_n, avr_oe_n, avr_counter_n,
                    avr_sreg_en_n, avr_si, avr_sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ctl_s = sync_q[SYNC_STAGES-1];
  assign {snes_s, we_n_s, oe_n_s} = ctl_s[6:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_prev <= ctl_s[0];
      if (ctl_s[0] && !sclk_prev && !ctl_s[2] && !busy)
        addr <= {addr[ADDR_W-2:0], ctl_s[1]};
      else if (recover && !ctl_s[3])
        addr <= (addr == '1) ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// SRAM bus controller: AVR timed read/write cycles and SNES pass-through on one SRAM port.
// Define SRAM_BUS_CTRL_DEBUG_EN to drive the debug bus; otherwise it is tied to zero.
//
// state     | meaning
// IDLE      | waiting for an AVR strobe edge or SNES request
// RD        | ce/oe low, read data captured on last cycle
// WR_SETUP  | ce low, write data driven, we still high
// WR_PULSE  | we low
// WR_HOLD   | we released, data still driven
// RECOVER   | all strobes high, optional address increment
// SNES      | SRAM handed to SNES address/data path
// TURN      | one idle cycle when leaving SNES
module sram_bus_ctrl import sram_bus_pkg::*; #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               avr_sclk,
  input  logic               avr_si,
  input  logic               avr_sreg_en_n,
  input  logic               avr_counter_n,
  input  logic               avr_oe_n,
  input  logic               avr_we_n,
  input  logic               avr_snes_mode,
  input  logic [DATA_W-1:0]  avr_data_in,
  output logic [DATA_W-1:0]  avr_data_out,
  output logic               avr_data_oe,
  input  logic [ADDR_W-1:0]  snes_addr,
  output logic [DATA_W-1:0]  snes_data_out,
  sram_bus_ctrl_if.master    sram,
  output logic               busy,
  output logic               err,
  output logic [DEBUG_W-1:0] debug
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state;
  logic [3:0]        timer;
  logic [ADDR_W-1:0] addr;
  logic              oe_n_s, we_n_s, snes_s;
  logic              oe_prev, we_prev, oe_fall, we_fall;
  logic              ce_n_q, oe_n_q, we_n_q, data_oe_q;
  logic [DATA_W-1:0] wdata_q;

  sram_addr_reg #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) u_addr_reg (
    .clk           (clk),
    .reset_n       (reset_n),
    .avr_sclk      (avr_sclk),
    .avr_si        (avr_si),
    .avr_sreg_en_n (avr_sreg_en_n),
    .avr_counter_n (avr_counter_n),
    .avr_oe_n      (avr_oe_n),
    .avr_we_n      (avr_we_n),
    .avr_snes_mode (avr_snes_mode),
    .busy          (busy),
    .recover       (state == ST_RECOVER),
    .addr          (addr),
    .oe_n_s        (oe_n_s),
    .we_n_s        (we_n_s),
    .snes_s        (snes_s)
  );

  // registered edge pulses give the extra cycle of strobe-to-FSM latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_prev <= 1'b1;
      we_prev <= 1'b1;
      oe_fall <= 1'b0;
      we_fall <= 1'b0;
    end else begin
      oe_prev <= oe_n_s;
      we_prev <= we_n_s;
      oe_fall <= oe_prev & ~oe_n_s;
      we_fall <= we_prev & ~we_n_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      data_oe_q     <= 1'b0;
      wdata_q       <= '0;
      avr_data_out  <= '0;
      snes_data_out <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (oe_fall && we_fall) begin
            err <= 1'b1;
          end else if (oe_fall) begin
            state  <= ST_RD;
            ce_n_q <= 1'b0;
            oe_n_q <= 1'b0;
            timer  <= WAIT_INIT;
            busy   <= 1'b1;
          end else if (we_fall) begin
            state     <= ST_WR_SETUP;
            ce_n_q    <= 1'b0;
            data_oe_q <= 1'b1;
            wdata_q   <= avr_data_in;
            busy      <= 1'b1;
          end else if (snes_s) begin
            state  <= ST_SNES;
            ce_n_q <= 1'b0;
            oe_n_q <= 1'b0;
          end
        end
        ST_RD: begin
          if (timer == 4'd0) begin
            avr_data_out <= sram.sram_data_in;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            state        <= ST_RECOVER;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        ST_WR_SETUP: begin
          we_n_q <= 1'b0;
          timer  <= WAIT_INIT;
          state  <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (timer == 4'd0) begin
            we_n_q <= 1'b1;
            state  <= ST_WR_HOLD;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        ST_WR_HOLD: begin
          ce_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
          state     <= ST_RECOVER;
        end
        ST_RECOVER: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_SNES: begin
          snes_data_out <= sram.sram_data_in;
          if (!snes_s) begin
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_TURN;
          end
        end
        ST_TURN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sram.sram_addr     = (state == ST_SNES) ? snes_addr : addr;
  assign sram.sram_data_out = wdata_q;
  assign sram.sram_data_oe  = data_oe_q;
  assign sram.sram_ce_n     = ce_n_q;
  assign sram.sram_oe_n     = oe_n_q;
  assign sram.sram_we_n     = we_n_q;
  assign avr_data_oe        = ~oe_n_s & (state != ST_SNES);

`ifdef SRAM_BUS_CTRL_DEBUG_EN
  assign debug = {state, busy, err, we_n_q, oe_n_q, ce_n_q};
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: address shift, read/write timing, wrap, error, SNES hand-over, reset.
module tb_sram_bus_ctrl;
  import sram_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        avr_sclk, avr_si, avr_sreg_en_n, avr_counter_n;
  logic        avr_oe_n, avr_we_n, avr_snes_mode;
  logic [7:0]  avr_data_in, avr_data_out, snes_data_out;
  logic        avr_data_oe, busy, err;
  logic [20:0] snes_addr;
  logic [7:0]  debug;

  int total = 0;
  int bad   = 0;

  int oe_low, we_low, ce_low, doe_cnt, viol, wr_cnt;
  logic [20:0] last_wr_addr;
  logic [7:0]  last_wr_data;
  logic        we_seen_prev = 1'b1;
  logic        got;

`ifdef SRAM_BUS_CTRL_DEBUG_EN
  localparam logic [7:0] DBG_IDLE = 8'h07;
`else
  localparam logic [7:0] DBG_IDLE = 8'h00;
`endif

  sram_bus_ctrl_if #(.ADDR_W(21), .DATA_W(8)) sram_bus ();

  sram_bus_ctrl #(.ADDR_W(21), .DATA_W(8), .WAIT_CYCLES(1), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avr_sclk      (avr_sclk),
    .avr_si        (avr_si),
    .avr_sreg_en_n (avr_sreg_en_n),
    .avr_counter_n (avr_counter_n),
    .avr_oe_n      (avr_oe_n),
    .avr_we_n      (avr_we_n),
    .avr_snes_mode (avr_snes_mode),
    .avr_data_in   (avr_data_in),
    .avr_data_out  (avr_data_out),
    .avr_data_oe   (avr_data_oe),
    .snes_addr     (snes_addr),
    .snes_data_out (snes_data_out),
    .sram          (sram_bus),
    .busy          (busy),
    .err           (err),
    .debug         (debug)
  );

  always #5 clk = ~clk;

  // pin monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sram_bus.sram_oe_n === 1'b0) oe_low++;
    if (sram_bus.sram_we_n === 1'b0) we_low++;
    if (sram_bus.sram_ce_n === 1'b0) ce_low++;
    if (sram_bus.sram_data_oe === 1'b1) doe_cnt++;
    if (sram_bus.sram_we_n === 1'b0 && sram_bus.sram_data_oe !== 1'b1) viol++;
    if (we_seen_prev === 1'b0 && sram_bus.sram_we_n === 1'b1 && sram_bus.sram_ce_n === 1'b0) begin
      wr_cnt++;
      last_wr_addr = sram_bus.sram_addr;
      last_wr_data = sram_bus.sram_data_out;
    end
    we_seen_prev = sram_bus.sram_we_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    oe_low = 0; we_low = 0; ce_low = 0; doe_cnt = 0; viol = 0;
  endtask

  task automatic shift_addr(input logic [20:0] a);
    avr_sreg_en_n = 1'b0;
    for (int i = 20; i >= 0; i--) begin
      avr_si = a[i];
      clocks(3);
      avr_sclk = 1'b1;
      clocks(3);
      avr_sclk = 1'b0;
    end
    clocks(4);
    avr_sreg_en_n = 1'b1;
    clocks(2);
  endtask

  task automatic do_write(input logic [7:0] d);
    avr_data_in = d;
    avr_we_n = 1'b0;
    clocks(12);
    avr_we_n = 1'b1;
    clocks(10);
  endtask

  initial begin
    reset_n = 1'b0;
    avr_sclk = 1'b0; avr_si = 1'b0; avr_sreg_en_n = 1'b1; avr_counter_n = 1'b1;
    avr_oe_n = 1'b1; avr_we_n = 1'b1; avr_snes_mode = 1'b0;
    avr_data_in = 8'h00; snes_addr = 21'h0;
    sram_bus.sram_data_in = 8'h00;
    wr_cnt = 0;
    clear_counts();
    #23;
    chk("rst_strobes", {sram_bus.sram_ce_n, sram_bus.sram_oe_n, sram_bus.sram_we_n}, 3'b111);
    chk("rst_drivers", {sram_bus.sram_data_oe, avr_data_oe}, 2'b00);
    chk("rst_busy_err", {busy, err}, 2'b00);
    chk("rst_data", {avr_data_out, snes_data_out}, 16'h0000);
    chk("rst_addr", sram_bus.sram_addr, 21'h0);
    chk("rst_debug", debug, DBG_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    clocks(3);

    // 1: shift address, single read
    shift_addr(21'h1ABCDE);
    chk("t1_addr", sram_bus.sram_addr, 21'h1ABCDE);
    sram_bus.sram_data_in = 8'h5A;
    clear_counts();
    avr_oe_n = 1'b0;
    clocks(5);
    chk("t1_avr_oe", avr_data_oe, 1'b1);
    clocks(5);
    avr_oe_n = 1'b1;
    clocks(10);
    chk("t1_oe_len", oe_low, 2);
    chk("t1_rdata", avr_data_out, 8'h5A);
    chk("t1_addr_hold", sram_bus.sram_addr, 21'h1ABCDE);
    chk("t1_idle", {busy, avr_data_oe}, 2'b00);

    // 2: auto-increment with wrap across two writes
    avr_counter_n = 1'b0;
    shift_addr(21'h1FFFFF);
    clear_counts();
    do_write(8'h11);
    chk("t2_wr1_addr", last_wr_addr, 21'h1FFFFF);
    chk("t2_wr1_data", last_wr_data, 8'h11);
    chk("t2_wrap", sram_bus.sram_addr, 21'h000000);
    do_write(8'h22);
    chk("t2_wr2_addr", last_wr_addr, 21'h000000);
    chk("t2_wr2_data", last_wr_data, 8'h22);
    chk("t2_wr_cnt", wr_cnt, 2);
    chk("t2_we_len", we_low, 4);
    chk("t2_doe_len", doe_cnt, 8);
    chk("t2_we_undriven", viol, 0);
    chk("t2_addr_after", sram_bus.sram_addr, 21'h000001);
    avr_counter_n = 1'b1;

    // 3: simultaneous oe/we edge
    clear_counts();
    chk("t3_err_before", err, 1'b0);
    avr_oe_n = 1'b0; avr_we_n = 1'b0;
    clocks(15);
    chk("t3_err", err, 1'b1);
    chk("t3_no_ce", ce_low, 0);
    avr_oe_n = 1'b1; avr_we_n = 1'b1;
    clocks(10);
    chk("t3_err_sticky", err, 1'b1);
    chk("t3_busy", busy, 1'b0);

    // 4: SNES request mid-write
    snes_addr = 21'h012345;
    sram_bus.sram_data_in = 8'hC3;
    avr_data_in = 8'h33;
    avr_we_n = 1'b0;
    clocks(5);
    avr_snes_mode = 1'b1;
    clocks(7);
    avr_we_n = 1'b1;
    clocks(10);
    chk("t4_wr_cnt", wr_cnt, 3);
    chk("t4_wr_addr", last_wr_addr, 21'h000001);
    chk("t4_wr_data", last_wr_data, 8'h33);
    chk("t4_snes_addr", sram_bus.sram_addr, 21'h012345);
    chk("t4_snes_strobes", {sram_bus.sram_ce_n, sram_bus.sram_oe_n, sram_bus.sram_we_n}, 3'b001);
    chk("t4_snes_busy", busy, 1'b0);
    chk("t4_snes_data", snes_data_out, 8'hC3);
    clear_counts();
    avr_oe_n = 1'b0;
    clocks(6);
    chk("t4_avr_oe_off", avr_data_oe, 1'b0);
    clocks(4);
    avr_oe_n = 1'b1;
    clocks(8);
    chk("t4_rdata_kept", avr_data_out, 8'h5A);
    chk("t4_still_snes", sram_bus.sram_addr, 21'h012345);
    chk("t4_no_we", we_low, 0);

    // 5: leave SNES through one TURN cycle
    avr_snes_mode = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b1) got = 1'b1;
    end
    chk("t5_turn_seen", got, 1'b1);
    chk("t5_turn_strobes", {sram_bus.sram_ce_n, sram_bus.sram_oe_n, sram_bus.sram_we_n}, 3'b111);
    @(negedge clk);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_strobes", {sram_bus.sram_ce_n, sram_bus.sram_oe_n, sram_bus.sram_we_n}, 3'b111);
    chk("t5_idle_addr", sram_bus.sram_addr, 21'h000001);
    clocks(3);
    chk("t5_stay_idle", busy, 1'b0);

    // 6: asynchronous reset in the middle of the write pulse
    avr_data_in = 8'h44;
    avr_we_n = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (sram_bus.sram_we_n === 1'b0) got = 1'b1;
    end
    chk("t6_pulse_seen", got, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_we_release", sram_bus.sram_we_n, 1'b1);
    chk("t6_data_release", sram_bus.sram_data_oe, 1'b0);
    chk("t6_ce_release", sram_bus.sram_ce_n, 1'b1);
    chk("t6_addr", sram_bus.sram_addr, 21'h0);
    chk("t6_busy_err", {busy, err}, 2'b00);
    avr_we_n = 1'b1;
    clocks(2);
    reset_n = 1'b1;
    clocks(5);
    chk("t6_after", {busy, sram_bus.sram_ce_n, sram_bus.sram_we_n}, 3'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
